// File: rtl/upd1771c_host_if.sv
// upd1771c_host_if: host byte FIFO replayed onto the uPD1771C parallel port using the DSB handshake
module upd1771c_host_if #(
  parameter int FIFO_DEPTH = 8,
  parameter int WR_PULSE = 8,
  parameter int GAP = 72,
  parameter int TIMEOUT = 4096
) (
  input  logic       CLK,
  input  logic       RESB,
  input  logic       CKEN,
  input  logic       HOST_WR,
  input  logic [7:0] HOST_D,
  input  logic       HOST_FIRST,
  output logic       HOST_FULL,
  output logic       HOST_BUSY,
  output logic       ERR,
  input  logic       ERR_CLR,
  output logic [7:0] SND_D,
  output logic       SND_NCS,
  output logic       SND_NWR,
  input  logic       SND_DSB
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(GAP > WR_PULSE ? GAP : WR_PULSE);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [2:0] {S_IDLE, S_WAIT_HI, S_STROBE, S_GAP, S_WAIT_LO, S_FLUSH} state_t;
  logic [8:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  state_t state_q, state_d;
  logic [7:0] snd_d_q, snd_d_d;
  logic strobe_n_q, strobe_n_d, cur_first_q, cur_first_d, dsb_q, dsb_d, err_q, err_d;
  logic [8:0] head;
  logic push, pop, start, tmo_err, tmo_hit, empty;
  assign head = mem_q[rd_ptr_q];
  assign empty = count_q == '0;
  assign HOST_FULL = count_q == (AW+1)'(FIFO_DEPTH);
  assign HOST_BUSY = !empty || state_q != S_IDLE;
  assign push = HOST_WR && !HOST_FULL;
  assign tmo_hit = tmo_q == TW'(TIMEOUT - 1);
  assign ERR = err_q;
  assign SND_D = snd_d_q;
  assign SND_NCS = strobe_n_q;
  assign SND_NWR = strobe_n_q;
  assign wr_ptr_d = wr_ptr_q + AW'(push);
  assign rd_ptr_d = rd_ptr_q + AW'(pop);
  assign count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
  // overflow is checked every CLK; a set event beats a same-cycle clear
  assign err_d = tmo_err || (HOST_WR && HOST_FULL) || (err_q && !ERR_CLR);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    tmo_d = tmo_q;
    snd_d_d = snd_d_q;
    strobe_n_d = strobe_n_q;
    cur_first_d = cur_first_q;
    dsb_d = dsb_q;
    pop = 1'b0;
    start = 1'b0;
    tmo_err = 1'b0;
    if (CKEN) begin
      dsb_d = SND_DSB;
      case (state_q)
        S_IDLE: begin
          start = !empty && head[8];
          if (!empty && !head[8]) begin
            state_d = S_WAIT_HI;
            tmo_d = '0;
          end
        end
        S_WAIT_HI: begin
          start = dsb_q;
          tmo_err = !dsb_q && tmo_hit;
          tmo_d = tmo_hit ? tmo_q : tmo_q + TW'(1);
        end
        S_STROBE: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WR_PULSE - 1)) begin
            strobe_n_d = 1'b1;
            cnt_d = '0;
            state_d = S_GAP;
          end
        end
        S_GAP: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(GAP - 1)) begin
            cnt_d = '0;
            tmo_d = '0;
            state_d = cur_first_q ? S_IDLE : S_WAIT_LO;
          end
        end
        S_WAIT_LO: begin
          tmo_err = dsb_q && tmo_hit;
          tmo_d = tmo_hit ? tmo_q : tmo_q + TW'(1);
          if (!dsb_q) state_d = S_IDLE;
        end
        S_FLUSH: begin
          pop = !empty && !head[8];
          if (empty || head[8]) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
      if (tmo_err) state_d = S_FLUSH;
      if (start) begin
        pop = 1'b1;
        snd_d_d = head[7:0];
        strobe_n_d = 1'b0;
        cur_first_d = head[8];
        cnt_d = '0;
        state_d = S_STROBE;
      end
    end
  end
  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      tmo_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      snd_d_q <= 8'hFF;
      strobe_n_q <= 1'b1;
      cur_first_q <= 1'b0;
      dsb_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      snd_d_q <= snd_d_d;
      strobe_n_q <= strobe_n_d;
      cur_first_q <= cur_first_d;
      dsb_q <= dsb_d;
      err_q <= err_d;
    end
  end
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= {HOST_FIRST, HOST_D};
  end
endmodule

// File: tb/tb_upd1771c_host_if.sv
// tb_upd1771c_host_if: scenario tasks against a chip-side DSB model and a byte-order reference
module tb_upd1771c_host_if;
  localparam int WR_PULSE = 8, GAP = 72, TIMEOUT = 4096, DEPTH = 8;
  logic clk = 0, rst_n = 1, cken = 1, host_wr = 0, host_first = 0, err_clr = 0, snd_dsb = 0;
  logic [7:0] host_d = 0, snd_d;
  logic host_full, host_busy, err, snd_ncs, snd_nwr;
  int errors = 0, checks = 0;
  int cyc = 0, cken_div = 1, rise_t = 0, fall_t = 0, fall_cyc = 0, err_cyc = -1, busy_fall_cyc = -1;
  bit dsb_auto = 0;
  logic prev_ncs = 1, prev_err = 0, prev_busy = 0;
  logic [7:0] sent_q[$], hold_q[$];
  int pulse_q[$], fall_cyc_q[$];

  upd1771c_host_if dut (
    .CLK(clk), .RESB(rst_n), .CKEN(cken), .HOST_WR(host_wr), .HOST_D(host_d),
    .HOST_FIRST(host_first), .HOST_FULL(host_full), .HOST_BUSY(host_busy), .ERR(err),
    .ERR_CLR(err_clr), .SND_D(snd_d), .SND_NCS(snd_ncs), .SND_NWR(snd_nwr), .SND_DSB(snd_dsb)
  );

  always #5 clk = ~clk;

  // chip model: DSB pulses high 20 cycles after each strobe's recovery, for 30 cycles
  always @(negedge clk) begin
    cyc++;
    if (prev_ncs && !snd_ncs) begin
      sent_q.push_back(snd_d);
      fall_cyc_q.push_back(cyc);
      fall_cyc = cyc;
      if (dsb_auto) rise_t = WR_PULSE + GAP + 20;
    end
    if (!prev_ncs && snd_ncs) begin
      pulse_q.push_back(cyc - fall_cyc);
      hold_q.push_back(snd_d);
    end
    if (!prev_err && err) err_cyc = cyc;
    if (prev_busy && !host_busy) busy_fall_cyc = cyc;
    prev_ncs = snd_ncs;
    prev_err = err;
    prev_busy = host_busy;
    if (fall_t > 0) begin
      fall_t--;
      if (fall_t == 0) snd_dsb = 0;
    end
    if (rise_t > 0) begin
      rise_t--;
      if (rise_t == 0) begin
        snd_dsb = 1;
        fall_t = 30;
      end
    end
    if (!dsb_auto) begin
      snd_dsb = 0;
      rise_t = 0;
      fall_t = 0;
    end
    cken = (cyc % cken_div) == 0;
  end

  task automatic wr(input logic [7:0] d, input logic f);
    host_wr = 1;
    host_d = d;
    host_first = f;
    @(negedge clk);
    host_wr = 0;
  endtask

  task automatic clear_mon();
    repeat (200) @(negedge clk);
    sent_q.delete();
    hold_q.delete();
    pulse_q.delete();
    fall_cyc_q.delete();
    err_cyc = -1;
    busy_fall_cyc = -1;
  endtask

  task automatic wait_busy_low(input int budget, output bit ok);
    int n = 0;
    while (host_busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = !host_busy;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2 rst_n = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({snd_d, snd_ncs, snd_nwr, host_full, host_busy, err} !== {8'hFF, 5'b11000}) begin
      errors++;
      $display("FAIL reset_values: got d=%h ncs=%b nwr=%b full=%b busy=%b err=%b want d=ff ncs=1 nwr=1 full=0 busy=0 err=0",
               snd_d, snd_ncs, snd_nwr, host_full, host_busy, err);
    end
    rst_n = 1;
    repeat (1000) @(negedge clk);
    checks++;
    if (sent_q.size() != 0) begin
      errors++;
      $display("FAIL reset_idle_strobes: got %0d strobes want 0", sent_q.size());
    end
    checks++;
    if (host_busy !== 1'b0 || snd_ncs !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle_busy: got busy=%b ncs=%b want busy=0 ncs=1", host_busy, snd_ncs);
    end
  endtask

  task automatic test_packet();
    logic [7:0] exp[$] = '{8'h02, 8'h80, 8'h35, 8'h15};
    bit ok;
    dsb_auto = 1;
    clear_mon();
    foreach (exp[i]) wr(exp[i], i == 0);
    wait_busy_low(3000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL packet_done: got busy=%b want 0 within 3000 cycles", host_busy);
    end
    checks++;
    if (sent_q.size() != exp.size()) begin
      errors++;
      $display("FAIL packet_count: got %0d strobes want %0d", sent_q.size(), exp.size());
    end
    for (int i = 0; i < sent_q.size() && i < exp.size(); i++) begin
      checks++;
      if (sent_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL packet_byte%0d: got %h want %h", i, sent_q[i], exp[i]);
      end
    end
    foreach (pulse_q[i]) begin
      checks++;
      if (pulse_q[i] != WR_PULSE || hold_q[i] !== sent_q[i]) begin
        errors++;
        $display("FAIL packet_pulse%0d: got len=%0d d=%h want len=%0d d=%h", i, pulse_q[i], hold_q[i], WR_PULSE, sent_q[i]);
      end
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL packet_err: got %b want 0", err);
    end
    checks++;
    if (fall_cyc_q.size() == 0 || busy_fall_cyc - fall_cyc_q[fall_cyc_q.size()-1] != WR_PULSE + GAP + 1) begin
      errors++;
      $display("FAIL packet_busy_fall: got %0d cycles after last strobe want %0d",
               fall_cyc_q.size() ? busy_fall_cyc - fall_cyc_q[fall_cyc_q.size()-1] : -1, WR_PULSE + GAP + 1);
    end
    dsb_auto = 0;
  endtask

  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      logic [7:0] exp[$];
      logic fq[$];
      bit ok;
      dsb_auto = 1;
      clear_mon();
      for (int p = 0; p < 2; p++) begin
        int len = $urandom_range(1, 3);
        for (int b = 0; b < len; b++) begin
          exp.push_back(8'($urandom));
          fq.push_back(b == 0);
        end
      end
      foreach (exp[i]) wr(exp[i], fq[i]);
      wait_busy_low(3000, ok);
      checks++;
      if (!ok || err !== 1'b0 || sent_q.size() != exp.size()) begin
        errors++;
        $display("FAIL random%0d_done: got ok=%b err=%b strobes=%0d want ok=1 err=0 strobes=%0d", it, ok, err, sent_q.size(), exp.size());
      end
      for (int i = 0; i < sent_q.size() && i < exp.size(); i++) begin
        checks++;
        if (sent_q[i] !== exp[i] || pulse_q[i] != WR_PULSE) begin
          errors++;
          $display("FAIL random%0d_byte%0d: got d=%h len=%0d want d=%h len=%0d", it, i, sent_q[i], pulse_q[i], exp[i], WR_PULSE);
        end
      end
    end
    dsb_auto = 0;
  endtask

  task automatic test_cken();
    bit ok;
    clear_mon();
    cken_div = 3;
    wr(8'h02, 1);
    wr(8'h80, 1);
    wait_busy_low(2000, ok);
    checks++;
    if (!ok || sent_q.size() != 2) begin
      errors++;
      $display("FAIL cken_done: got ok=%b strobes=%0d want ok=1 strobes=2", ok, sent_q.size());
    end
    foreach (pulse_q[i]) begin
      checks++;
      if (pulse_q[i] != 3 * WR_PULSE) begin
        errors++;
        $display("FAIL cken_pulse%0d: got %0d want %0d", i, pulse_q[i], 3 * WR_PULSE);
      end
    end
    checks++;
    if (fall_cyc_q.size() != 2 || fall_cyc_q[1] - fall_cyc_q[0] != 3 * (WR_PULSE + GAP + 1)) begin
      errors++;
      $display("FAIL cken_spacing: got %0d want %0d",
               fall_cyc_q.size() == 2 ? fall_cyc_q[1] - fall_cyc_q[0] : -1, 3 * (WR_PULSE + GAP + 1));
    end
    cken_div = 1;
  endtask

  task automatic test_timeout();
    logic [7:0] exp[$] = '{8'h02, 8'h80, 8'h35, 8'h15};
    int n = 0;
    int t0;
    bit ok;
    clear_mon();
    foreach (exp[i]) wr(exp[i], i == 0);
    while (!err && n < 6000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    t0 = fall_cyc_q.size() ? fall_cyc_q[0] : 0;
    checks++;
    if (err_cyc - t0 != WR_PULSE + GAP + 1 + TIMEOUT) begin
      errors++;
      $display("FAIL timeout_err_time: got %0d cycles after strobe want %0d", err_cyc - t0, WR_PULSE + GAP + 1 + TIMEOUT);
    end
    wait_busy_low(100, ok);
    checks++;
    if (!ok || sent_q.size() != 1 || sent_q[0] !== 8'h02) begin
      errors++;
      $display("FAIL timeout_flush: got ok=%b strobes=%0d want ok=1 strobes=1 of 02", ok, sent_q.size());
    end
    wr(8'h02, 1);
    wait_busy_low(200, ok);
    checks++;
    if (!ok || sent_q.size() != 2 || sent_q[1] !== 8'h02 || err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_next_packet: got ok=%b strobes=%0d err=%b want ok=1 strobes=2 err=1", ok, sent_q.size(), err);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    clear_mon();
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: got %b want 0", err);
    end
    for (int i = 0; i < DEPTH + 1; i++) begin
      wr(8'($urandom), 0);
      if (i == DEPTH - 1) begin
        checks++;
        if (host_full !== 1'b1 || err !== 1'b0) begin
          errors++;
          $display("FAIL overflow_full: got full=%b err=%b want full=1 err=0", host_full, err);
        end
      end
    end
    checks++;
    if (err !== 1'b1 || host_full !== 1'b1) begin
      errors++;
      $display("FAIL overflow_err: got err=%b full=%b want err=1 full=1", err, host_full);
    end
    err_clr = 1;
    wr(8'h55, 0);
    err_clr = 0;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set_wins: got %b want 1", err);
    end
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clear: got %b want 0", err);
    end
    wait_busy_low(TIMEOUT + 200, ok);
    checks++;
    if (!ok || sent_q.size() != 0 || err !== 1'b1 || host_full !== 1'b0) begin
      errors++;
      $display("FAIL overflow_drain: got ok=%b strobes=%0d err=%b full=%b want ok=1 strobes=0 err=1 full=0",
               ok, sent_q.size(), err, host_full);
    end
  endtask

  task automatic test_async_reset();
    int n = 0;
    clear_mon();
    wr(8'h02, 1);
    wr(8'h11, 1);
    wr(8'h22, 1);
    while (snd_ncs && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (snd_ncs !== 1'b0) begin
      errors++;
      $display("FAIL areset_setup: got ncs=%b want 0", snd_ncs);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if (snd_ncs !== 1'b1 || snd_nwr !== 1'b1) begin
      errors++;
      $display("FAIL areset_immediate: got ncs=%b nwr=%b want 1 1", snd_ncs, snd_nwr);
    end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (host_busy !== 1'b0 || host_full !== 1'b0 || snd_d !== 8'hFF || err !== 1'b0) begin
      errors++;
      $display("FAIL areset_state: got busy=%b full=%b d=%h err=%b want 0 0 ff 0", host_busy, host_full, snd_d, err);
    end
    sent_q.delete();
    repeat (300) @(negedge clk);
    checks++;
    if (sent_q.size() != 0 || host_busy !== 1'b0) begin
      errors++;
      $display("FAIL areset_fifo_empty: got strobes=%0d busy=%b want 0 0", sent_q.size(), host_busy);
    end
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_packet();
    test_random();
    test_cken();
    test_timeout();
    test_overflow();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
